// File: rtl/pulse_to_level.sv
// Start/stop strobe to level converter with edge strobes and a saturating
// window-length counter. All outputs are registered; rst_n is an active-high sync reset.
module pulse_to_level #(
  parameter int CNT_W         = 16,
  parameter bit STOP_PRIORITY = 1'b1,
  parameter bit EDGE_DETECT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  output logic             level,
  output logic             level_rise,
  output logic             level_fall,
  output logic [CNT_W-1:0] duration,
  output logic [CNT_W-1:0] last_duration
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic s_ev, p_ev, level_nxt;

  generate
    if (EDGE_DETECT) begin : g_edge
      logic start_d, stop_d;
      always_ff @(posedge clk) begin
        if (rst_n) begin
          start_d <= 1'b0;
          stop_d  <= 1'b0;
        end else begin
          start_d <= start;
          stop_d  <= stop;
        end
      end
      assign s_ev = start & ~start_d;
      assign p_ev = stop & ~stop_d;
    end else begin : g_raw
      assign s_ev = start;
      assign p_ev = stop;
    end
  endgenerate

  // A simultaneous start/stop forces the level regardless of its current state.
  always_comb begin
    level_nxt = level;
    if (s_ev && p_ev) level_nxt = !STOP_PRIORITY;
    else if (s_ev)    level_nxt = 1'b1;
    else if (p_ev)    level_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      level         <= 1'b0;
      level_rise    <= 1'b0;
      level_fall    <= 1'b0;
      duration      <= '0;
      last_duration <= '0;
    end else begin
      level      <= level_nxt;
      level_rise <= level_nxt & ~level;
      level_fall <= ~level_nxt & level;
      if (level_nxt && !level)
        duration <= {{(CNT_W-1){1'b0}}, 1'b1};
      else if (level_nxt && duration != CNT_MAX)
        duration <= duration + 1'b1;
      if (!level_nxt && level)
        last_duration <= duration;
    end
  end

endmodule

// File: tb/tb_pulse_to_level.sv
// Four parameter variants share one stimulus stream; a per-variant reference model
// pushes expected outputs each cycle, popped and compared after the clock edge.
module tb_pulse_to_level;

  localparam int NI = 4;
  // variant: 0 default, 1 start-wins, 2 edge-detect, 3 4-bit counters
  localparam logic [NI-1:0] SPV = 4'b1101;
  localparam logic [NI-1:0] EDV = 4'b0100;

  logic clk = 1'b0;
  logic rst_n = 1'b1, start = 1'b0, stop = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0] lvl_a, rise_a, fall_a;
  logic [15:0] dur0, dur1, dur2, last0, last1, last2;
  logic [3:0]  dur3, last3;
  logic [15:0] dur_a [NI];
  logic [15:0] last_a [NI];

  always_comb begin
    dur_a[0] = dur0;  dur_a[1] = dur1;  dur_a[2] = dur2;  dur_a[3] = {12'd0, dur3};
    last_a[0] = last0; last_a[1] = last1; last_a[2] = last2; last_a[3] = {12'd0, last3};
  end

  pulse_to_level u0 (.clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .level(lvl_a[0]), .level_rise(rise_a[0]), .level_fall(fall_a[0]),
    .duration(dur0), .last_duration(last0));
  pulse_to_level #(.STOP_PRIORITY(1'b0)) u1 (.clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .level(lvl_a[1]), .level_rise(rise_a[1]), .level_fall(fall_a[1]),
    .duration(dur1), .last_duration(last1));
  pulse_to_level #(.EDGE_DETECT(1'b1)) u2 (.clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .level(lvl_a[2]), .level_rise(rise_a[2]), .level_fall(fall_a[2]),
    .duration(dur2), .last_duration(last2));
  pulse_to_level #(.CNT_W(4)) u3 (.clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .level(lvl_a[3]), .level_rise(rise_a[3]), .level_fall(fall_a[3]),
    .duration(dur3), .last_duration(last3));

  typedef struct {
    logic        lvl, rise, fall;
    logic [15:0] dur, last;
  } exp_t;

  exp_t exp_q[$];

  int n_cmp = 0, n_err = 0;
  int rise_cnt2 = 0, fall_cnt2 = 0;

  logic        m_lvl [NI];
  logic        m_sd  [NI];
  logic        m_pd  [NI];
  logic [15:0] m_dur [NI];
  logic [15:0] m_last[NI];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour: what each variant should show in the cycle after this edge.
  task automatic push_expected(input logic s, input logic p, input logic r);
    for (int i = 0; i < NI; i++) begin
      exp_t e;
      logic se, pe, nl;
      logic [15:0] mx;
      mx = (i == 3) ? 16'd15 : 16'hFFFF;
      se = EDV[i] ? (s & ~m_sd[i]) : s;
      pe = EDV[i] ? (p & ~m_pd[i]) : p;
      if (r) begin
        e = '{lvl: 1'b0, rise: 1'b0, fall: 1'b0, dur: 16'd0, last: 16'd0};
        m_sd[i] = 1'b0; m_pd[i] = 1'b0;
      end else begin
        if (se && pe)  nl = ~SPV[i];
        else if (se)   nl = 1'b1;
        else if (pe)   nl = 1'b0;
        else           nl = m_lvl[i];
        e.lvl  = nl;
        e.rise = nl && !m_lvl[i];
        e.fall = !nl && m_lvl[i];
        if (e.rise)                   e.dur = 16'd1;
        else if (nl && m_dur[i] < mx) e.dur = m_dur[i] + 16'd1;
        else                          e.dur = m_dur[i];
        e.last = e.fall ? m_dur[i] : m_last[i];
        m_sd[i] = s; m_pd[i] = p;
      end
      m_lvl[i] = e.lvl; m_dur[i] = e.dur; m_last[i] = e.last;
      exp_q.push_back(e);
    end
  endtask

  task automatic step(input logic s, input logic p, input logic r = 1'b0);
    start = s; stop = p; rst_n = r;
    push_expected(s, p, r);
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      exp_t e;
      e = exp_q.pop_front();
      chk($sformatf("u%0d.level", i),         lvl_a[i],  e.lvl);
      chk($sformatf("u%0d.level_rise", i),    rise_a[i], e.rise);
      chk($sformatf("u%0d.level_fall", i),    fall_a[i], e.fall);
      chk($sformatf("u%0d.duration", i),      dur_a[i],  e.dur);
      chk($sformatf("u%0d.last_duration", i), last_a[i], e.last);
    end
    rise_cnt2 += rise_a[2];
    fall_cnt2 += fall_a[2];
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      m_lvl[i] = 1'b0; m_sd[i] = 1'b0; m_pd[i] = 1'b0; m_dur[i] = 16'd0; m_last[i] = 16'd0;
    end

    // reset then idle
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    chk("reset.level", lvl_a, 4'b0000);
    idle(3);
    chk("idle.level", lvl_a, 4'b0000);

    // basic window: start cycle 0, stop cycle 3
    step(1'b1, 1'b0);
    chk("basic.rise_c1", rise_a[0], 1'b1);
    idle(2);
    step(1'b0, 1'b1);
    chk("basic.fall_c4", fall_a[0], 1'b1);
    chk("basic.last", last0, 16'd3);
    idle(2);

    // redundant start/stop pulses
    step(1'b1, 1'b0); idle(1); step(1'b1, 1'b0); idle(2);
    step(1'b0, 1'b1); idle(1); step(1'b0, 1'b1); idle(2);
    chk("redund.last", last0, 16'd5);
    chk("redund.level", lvl_a[0], 1'b0);

    // simultaneous start & stop while high
    step(1'b1, 1'b0); idle(2);
    step(1'b1, 1'b1);
    chk("simul.stop_wins", lvl_a[0], 1'b0);
    chk("simul.start_wins", lvl_a[1], 1'b1);
    chk("simul.dur_keeps", dur1, 16'd4);
    step(1'b0, 1'b1); idle(2);

    // held start 4 cycles, held stop 3 cycles
    rise_cnt2 = 0; fall_cnt2 = 0;
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1);
    idle(2);
    chk("edge.rise_count", rise_cnt2, 1);
    chk("edge.fall_count", fall_cnt2, 1);
    chk("edge.last", last2, 16'd4);
    chk("raw.last", last0, 16'd4);

    // 20-cycle window saturates the 4-bit counter
    step(1'b1, 1'b0); idle(19);
    chk("sat.dur", dur3, 4'd15);
    step(1'b0, 1'b1);
    chk("sat.last", last3, 4'd15);
    chk("wide.last", last0, 16'd20);
    idle(1);

    // reset mid-window: level drops, no fall, last kept at reset value
    step(1'b1, 1'b0); idle(3);
    step(1'b0, 1'b0, 1'b1);
    chk("rst_mid.level", lvl_a[0], 1'b0);
    chk("rst_mid.fall", fall_a[0], 1'b0);
    idle(2);

    if (exp_q.size() != 0) chk("queue.drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pulse_to_level.md
Name: pulse_to_level

Overview:
Converts single-cycle start/stop pulses into a registered level. The level goes high after a start pulse and stays high until a stop pulse. It also reports the level's edges and how long it was high. Used where a control FSM issues begin/end strobes and downstream logic needs a continuous enable window.

Parameters:
CNT_W, 16, width of the duration counters (≥2).
STOP_PRIORITY, 1, start and stop qualified in the same cycle: 1 = stop wins, 0 = start wins.
EDGE_DETECT, 0, 1 = start/stop are rising-edge detected internally, so a multi-cycle high counts once; 0 = every sampled-high cycle is an event.

Ports:
clk  input  1  clock; all logic on rising edge.
rst_n  input  1  synchronous reset, ACTIVE-HIGH despite the name (reset when rst_n=1 at a clk rising edge).
start  input  1  start pulse, synchronous to clk.
stop  input  1  stop pulse, synchronous to clk.
level  output  1  registered level output.
level_rise  output  1  one-cycle strobe, high in the first cycle level is 1.
level_fall  output  1  one-cycle strobe, high in the first cycle level is 0 after being 1.
duration  output  CNT_W  cycles level has been high in the current window (saturating).
last_duration  output  CNT_W  duration of the most recently completed window.

Behaviour:
- Reset (sync, active-high): level=0, level_rise=0, level_fall=0, duration=0, last_duration=0. Edge-detect history registers are cleared to 0.
  - Reset dominates start/stop in the same cycle.
  - Reset mid-window drops level with no level_fall and no last_duration update.
- Event qualification:
  - EDGE_DETECT=0: s_ev=start, p_ev=stop.
  - EDGE_DETECT=1: s_ev=start & ~start_d and p_ev=stop & ~stop_d, where *_d are 1-cycle registered copies.
- Level update, one-cycle latency: an event sampled at edge N changes level at edge N (visible in cycle N+1).
  - level=0 and s_ev → level=1.
  - level=1 and p_ev → level=0.
  - s_ev while level=1 → no effect; the window does not restart and duration is not cleared.
  - p_ev while level=0 → no effect.
- Simultaneous s_ev & p_ev:
  - STOP_PRIORITY=1: result is level=0 whatever the current state.
  - STOP_PRIORITY=0: result is level=1.
- Strobes: level_rise and level_fall are registered and coincide with the cycle level changes (level_rise = level & ~level_prev). Exactly one cycle wide.
- Duration counter:
  - Loads 1 on the cycle level rises.
  - Increments each cycle level stays 1.
  - Saturates at 2^CNT_W-1.
  - Holds its value while level=0.
- last_duration: on a falling transition, captures the final duration value (cycles level was high). It updates in the same cycle as level_fall.
- No combinational path from inputs to outputs.

Test Plan:
- Reset then idle: rst_n=1 for 2 cycles, then 0 → all outputs 0; no start → level stays 0.
- Basic window, 10-cycle clock: start high 1 cycle at cycle 0, stop high 1 cycle at cycle 3.
  - level=1 for cycles 1–3 and 0 from cycle 4.
  - level_rise at cycle 1, level_fall at cycle 4.
  - last_duration=3.
- Redundant pulses: start at cycles 0 and 2, stop at cycles 5 and 7.
  - A single window: level rises once (cycle 1) and falls once (cycle 6).
  - Second start and second stop ignored; last_duration=5.
- Simultaneous start & stop while level=1:
  - STOP_PRIORITY=1 → level 0 next cycle.
  - STOP_PRIORITY=0 → level stays 1 and duration keeps counting.
- EDGE_DETECT=1: start held high 4 cycles then stop held high 3 cycles.
  - Level rises once and falls once; holding stop gives no repeat events.
  - With EDGE_DETECT=0, the same held start followed by a 1-cycle stop ends the window at the stop.
- Saturation/reset: CNT_W=4, window of 20 cycles → duration saturates at 15 and last_duration=15. Reset asserted mid-window → level=0 next cycle, no level_fall.
